// File: rtl/scarv_soc_bram_bus_adapter_if.sv
// rtl/scarv_soc_bram_bus_adapter_if.sv - SoC memory-bus requester port (req/gnt request, recv/ack response)
interface scarv_soc_bram_bus_adapter_if;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );
endinterface

// File: rtl/scarv_soc_bram_bus_adapter.sv
// rtl/scarv_soc_bram_bus_adapter.sv - bridges one SoC memory-bus port onto a 1-cycle-latency BRAM port
module scarv_soc_bram_bus_adapter #(
    parameter  int DEPTH    = 1024,
    parameter  int WRITE_EN = 1,
    localparam int LW       = $clog2(DEPTH)
) (
    input  logic                              clka,
    input  logic                              rsta,
    scarv_soc_bram_bus_adapter_if.slave       mem,
    output logic                              bram_en,
    output logic [3:0]                        bram_we,
    output logic [LW-1:0]                     bram_addr,
    output logic [31:0]                       bram_din,
    input  logic [31:0]                       bram_dout
);

    localparam logic WR_OK = (WRITE_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        error_q, error_d;
    logic        rd_q,    rd_d;
    logic [31:0] hold_q,  hold_d;

    logic        addr_hi_bad;
    logic        gnt;
    logic        accept;
    logic        bad;

    generate
        if (LW < 32) begin : g_hi
            assign addr_hi_bad = |mem.mem_addr[31:LW];
        end else begin : g_nohi
            assign addr_hi_bad = 1'b0;
        end
    endgenerate

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q <= ST_IDLE;
            error_q <= 1'b0;
            rd_q    <= 1'b0;
            hold_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            rd_q    <= rd_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        gnt       = !rsta && ((state_q == ST_IDLE) || mem.mem_ack);
        accept    = mem.mem_req && gnt;
        bad       = addr_hi_bad || (|mem.mem_addr[1:0]) || (mem.mem_wen && !WR_OK);

        bram_en   = accept && !bad;
        bram_we   = (bram_en && mem.mem_wen && WR_OK) ? mem.mem_strb : 4'h0;
        bram_addr = mem.mem_addr[LW-1:0];
        bram_din  = mem.mem_wdata;

        state_d   = state_q;
        error_d   = error_q;
        rd_d      = rd_q;
        hold_d    = hold_q;

        case (state_q)
            ST_RESP: begin
                if (mem.mem_ack) begin
                    state_d = ST_IDLE;
                    error_d = 1'b0;
                    rd_d    = 1'b0;
                    hold_d  = 32'h0;
                end else begin
                    // BRAM output is only valid now; capture it before it is lost.
                    state_d = ST_HOLD;
                    if (rd_q) begin
                        hold_d = bram_dout;
                    end
                end
            end
            ST_HOLD: begin
                if (mem.mem_ack) begin
                    state_d = ST_IDLE;
                    error_d = 1'b0;
                    rd_d    = 1'b0;
                    hold_d  = 32'h0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            state_d = ST_RESP;
            error_d = bad;
            rd_d    = !mem.mem_wen && !bad;
            hold_d  = 32'h0;
        end

        mem.mem_gnt   = gnt;
        mem.mem_recv  = (state_q != ST_IDLE);
        mem.mem_error = (state_q != ST_IDLE) && error_q;
        if (!rd_q) begin
            mem.mem_rdata = 32'h0;
        end else if (state_q == ST_RESP) begin
            mem.mem_rdata = bram_dout;
        end else if (state_q == ST_HOLD) begin
            mem.mem_rdata = hold_q;
        end else begin
            mem.mem_rdata = 32'h0;
        end
    end

endmodule

// File: tb/tb_scarv_soc_bram_bus_adapter.sv
// tb/tb_scarv_soc_bram_bus_adapter.sv - directed self-checking bench for scarv_soc_bram_bus_adapter
module tb_scarv_soc_bram_bus_adapter;

    logic clk;
    logic rsta;

    scarv_soc_bram_bus_adapter_if m_if ();
    scarv_soc_bram_bus_adapter_if r_if ();

    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;

    logic        rom_en;
    logic [3:0]  rom_we;
    logic [9:0]  rom_addr;
    logic [31:0] rom_din;
    logic [31:0] rom_dout;

    int n_checks;
    int n_errors;

    logic [31:0] ram [0:255];

    scarv_soc_bram_bus_adapter #(.DEPTH(1024), .WRITE_EN(1)) dut (
        .clka      (clk),
        .rsta      (rsta),
        .mem       (m_if.slave),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    scarv_soc_bram_bus_adapter #(.DEPTH(1024), .WRITE_EN(0)) dut_rom (
        .clka      (clk),
        .rsta      (rsta),
        .mem       (r_if.slave),
        .bram_en   (rom_en),
        .bram_we   (rom_we),
        .bram_addr (rom_addr),
        .bram_din  (rom_din),
        .bram_dout (rom_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_dout = 32'h0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)      return 32'hDEADBEEF;
        else if (i == 8) return 32'h12345678;
        else if (i == 9) return 32'hCAFEF00D;
        else if (i < 4)  return 32'hA0000000 + 32'(i);
        else             return 32'(i) * 32'h01010101;
    endfunction

    // BRAM model: read-first, 1-cycle latency; dout is poisoned when not enabled.
    always @(posedge clk) begin
        if (rsta) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            bram_dout <= 32'hBAD0BAD0;
        end else if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) ram[bram_addr[9:2]][8*b +: 8] <= bram_din[8*b +: 8];
            end
            bram_dout <= ram[bram_addr[9:2]];
        end else begin
            bram_dout <= 32'hBAD0BAD0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rsta = 1'b1;
        m_if.mem_req = 1'b1; m_if.mem_wen = 1'b0; m_if.mem_strb = 4'h0;
        m_if.mem_addr = 32'h10; m_if.mem_wdata = 32'h0; m_if.mem_ack = 1'b1;
        r_if.mem_req = 1'b0; r_if.mem_wen = 1'b0; r_if.mem_strb = 4'h0;
        r_if.mem_addr = 32'h0; r_if.mem_wdata = 32'h0; r_if.mem_ack = 1'b1;
        tick(); tick();
        check("rst_recv",  32'(m_if.mem_recv),  32'h0);
        check("rst_gnt",   32'(m_if.mem_gnt),   32'h0);
        check("rst_error", 32'(m_if.mem_error), 32'h0);
        check("rst_en",    32'(bram_en),        32'h0);
        rsta = 1'b0;
        m_if.mem_req = 1'b0;
        tick();

        // single read with ack held high
        m_if.mem_req = 1'b1; m_if.mem_addr = 32'h10;
        #1;
        check("t1_gnt",  32'(m_if.mem_gnt), 32'h1);
        check("t1_en",   32'(bram_en),      32'h1);
        check("t1_addr", 32'(bram_addr),    32'h10);
        check("t1_we",   32'(bram_we),      32'h0);
        tick();
        m_if.mem_req = 1'b0;
        #1;
        check("t1_recv",  32'(m_if.mem_recv),  32'h1);
        check("t1_rdata", m_if.mem_rdata,      32'hDEADBEEF);
        check("t1_error", 32'(m_if.mem_error), 32'h0);
        tick();
        check("t1_idle", 32'(m_if.mem_recv), 32'h0);

        // four back-to-back reads
        for (int i = 0; i < 4; i++) begin
            m_if.mem_req = 1'b1; m_if.mem_addr = 32'(4 * i);
            #1;
            check("t2_gnt", 32'(m_if.mem_gnt), 32'h1);
            if (i > 0) begin
                check("t2_recv",  32'(m_if.mem_recv), 32'h1);
                check("t2_rdata", m_if.mem_rdata,     32'hA0000000 + 32'(i - 1));
            end
            tick();
        end
        m_if.mem_req = 1'b0;
        #1;
        check("t2_recv_last",  32'(m_if.mem_recv), 32'h1);
        check("t2_rdata_last", m_if.mem_rdata,     32'hA0000003);
        tick();
        check("t2_idle", 32'(m_if.mem_recv), 32'h0);

        // stalled read, next request waiting behind it
        m_if.mem_req = 1'b1; m_if.mem_addr = 32'h20; m_if.mem_ack = 1'b0;
        #1;
        check("t3_gnt0", 32'(m_if.mem_gnt), 32'h1);
        tick();
        m_if.mem_addr = 32'h24;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_recv",  32'(m_if.mem_recv), 32'h1);
            check("t3_rdata", m_if.mem_rdata,     32'h12345678);
            check("t3_gnt",   32'(m_if.mem_gnt),  32'h0);
            check("t3_en",    32'(bram_en),       32'h0);
            tick();
        end
        m_if.mem_ack = 1'b1;
        #1;
        check("t3_ack_recv",  32'(m_if.mem_recv), 32'h1);
        check("t3_ack_rdata", m_if.mem_rdata,     32'h12345678);
        check("t3_ack_gnt",   32'(m_if.mem_gnt),  32'h1);
        check("t3_ack_addr",  32'(bram_addr),     32'h24);
        tick();
        m_if.mem_req = 1'b0;
        #1;
        check("t3_next_recv",  32'(m_if.mem_recv), 32'h1);
        check("t3_next_rdata", m_if.mem_rdata,     32'hCAFEF00D);
        tick();
        check("t3_idle", 32'(m_if.mem_recv), 32'h0);

        // out-of-range then misaligned
        m_if.mem_req = 1'b1; m_if.mem_addr = 32'h400;
        #1;
        check("t4_oor_en",  32'(bram_en),      32'h0);
        check("t4_oor_gnt", 32'(m_if.mem_gnt), 32'h1);
        tick();
        m_if.mem_addr = 32'h2;
        #1;
        check("t4_oor_recv",  32'(m_if.mem_recv),  32'h1);
        check("t4_oor_error", 32'(m_if.mem_error), 32'h1);
        check("t4_oor_rdata", m_if.mem_rdata,      32'h0);
        check("t4_mis_en",    32'(bram_en),        32'h0);
        tick();
        m_if.mem_req = 1'b0;
        #1;
        check("t4_mis_recv",  32'(m_if.mem_recv),  32'h1);
        check("t4_mis_error", 32'(m_if.mem_error), 32'h1);
        tick();

        // partial-strobe write to RAM, full write to ROM
        m_if.mem_req = 1'b1; m_if.mem_wen = 1'b1; m_if.mem_addr = 32'h8;
        m_if.mem_wdata = 32'hA5A5A5A5; m_if.mem_strb = 4'h3;
        r_if.mem_req = 1'b1; r_if.mem_wen = 1'b1; r_if.mem_addr = 32'h8;
        r_if.mem_wdata = 32'hA5A5A5A5; r_if.mem_strb = 4'hF;
        #1;
        check("t5_we",      32'(bram_we),      32'h3);
        check("t5_en",      32'(bram_en),      32'h1);
        check("t5_din",     bram_din,          32'hA5A5A5A5);
        check("t5_rom_en",  32'(rom_en),       32'h0);
        check("t5_rom_we",  32'(rom_we),       32'h0);
        check("t5_rom_gnt", 32'(r_if.mem_gnt), 32'h1);
        tick();
        m_if.mem_req = 1'b0; m_if.mem_wen = 1'b0;
        r_if.mem_req = 1'b0; r_if.mem_wen = 1'b0;
        #1;
        check("t5_recv",      32'(m_if.mem_recv),  32'h1);
        check("t5_error",     32'(m_if.mem_error), 32'h0);
        check("t5_rdata",     m_if.mem_rdata,      32'h0);
        check("t5_rom_recv",  32'(r_if.mem_recv),  32'h1);
        check("t5_rom_error", 32'(r_if.mem_error), 32'h1);
        tick();
        m_if.mem_req = 1'b1; m_if.mem_addr = 32'h8;
        tick();
        m_if.mem_req = 1'b0;
        #1;
        check("t5_readback", m_if.mem_rdata, 32'hA000A5A5);
        tick();

        // reset while an error response is stalled
        m_if.mem_req = 1'b1; m_if.mem_addr = 32'h400; m_if.mem_ack = 1'b0;
        tick();
        m_if.mem_req = 1'b0;
        #1;
        check("t6_pre_recv",  32'(m_if.mem_recv),  32'h1);
        check("t6_pre_error", 32'(m_if.mem_error), 32'h1);
        rsta = 1'b1;
        #1;
        check("t6_rst_recv",  32'(m_if.mem_recv),  32'h0);
        check("t6_rst_error", 32'(m_if.mem_error), 32'h0);
        check("t6_rst_gnt",   32'(m_if.mem_gnt),   32'h0);
        tick();
        rsta = 1'b0; m_if.mem_ack = 1'b1;
        #1;
        check("t6_post_recv", 32'(m_if.mem_recv), 32'h0);
        m_if.mem_req = 1'b1; m_if.mem_addr = 32'h10;
        tick();
        m_if.mem_req = 1'b0;
        #1;
        check("t6_read_recv",  32'(m_if.mem_recv),  32'h1);
        check("t6_read_rdata", m_if.mem_rdata,      32'hDEADBEEF);
        check("t6_read_error", 32'(m_if.mem_error), 32'h0);
        tick();
        check("t6_idle", 32'(m_if.mem_recv), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
